// File: rtl/fast_8n1_uart_rx_if.sv
// Receive-side byte handshake: the receiver presents RX_DATA/RX_VALID,
// the consumer answers with RX_ACK.
interface fast_8n1_uart_rx_if #(
  parameter int BYTE_W = 8
);
  logic [BYTE_W-1:0] RX_DATA;
  logic              RX_VALID;
  logic              RX_ACK;

  modport master (
    output RX_DATA,
    output RX_VALID,
    input  RX_ACK
  );

  modport slave (
    input  RX_DATA,
    input  RX_VALID,
    output RX_ACK
  );
endinterface

// File: rtl/fast_8n1_uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit 3-sample majority vote,
// one-entry holding register with valid/ack handshake and error pulses.
module fast_8n1_uart_rx #(
  parameter int SYSCLK_F = 24000000,
  parameter int BYTE_W   = 8,
  parameter int BAUDRATE = 500000
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               RX_LINE,
  fast_8n1_uart_rx_if.master rx,
  output logic               FRAME_ERR,
  output logic               OVERRUN,
  output logic               BUSY
);

  localparam int CYC_PER_BIT = SYSCLK_F / BAUDRATE;
  localparam int MID         = CYC_PER_BIT / 2;
  localparam int CTR_W       = $clog2(CYC_PER_BIT);
  localparam int IDX_W       = $clog2(BYTE_W);

  localparam logic [CTR_W-1:0] CTR_LAST   = CTR_W'(CYC_PER_BIT - 1);
  localparam logic [CTR_W-1:0] SAMP_EARLY = CTR_W'(MID - 1);
  localparam logic [CTR_W-1:0] SAMP_MID   = CTR_W'(MID);
  localparam logic [CTR_W-1:0] SAMP_LATE  = CTR_W'(MID + 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BYTE_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, rxs, rxs_prev;
  logic [CTR_W-1:0]    ctr_q, ctr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BYTE_W-1:0]   shreg_q, shreg_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic [1:0]          samp_q, samp_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                ovr_q, ovr_d;
  logic                maj, at_decide, at_wrap;

  // Synchroniser resets to the idle (high) level so no false start after reset.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1_q  <= RX_LINE;
      rxs      <= sync1_q;
      rxs_prev <= rxs;
    end
  end

  assign maj       = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);
  assign at_decide = (ctr_q == SAMP_LATE);
  assign at_wrap   = (ctr_q == CTR_LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      samp_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      samp_q  <= samp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // The third majority sample is the live rxs in the decision cycle itself.
  always_comb begin
    state_d = state_q;
    ctr_d   = at_wrap ? '0 : ctr_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    samp_d  = samp_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx.RX_ACK;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (ctr_q == SAMP_EARLY) samp_d[1] = rxs;
    if (ctr_q == SAMP_MID)   samp_d[0] = rxs;

    unique case (state_q)
      IDLE: begin
        ctr_d = '0;
        if (en && rxs_prev && !rxs) state_d = START;
      end
      START: begin
        if (at_decide && maj) begin
          state_d = IDLE;
          ctr_d   = '0;
        end else if (at_wrap) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_decide) shreg_d = {maj, shreg_q[BYTE_W-1:1]};
        if (at_wrap) begin
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      STOP: begin
        // Leave at mid-stop so a following start edge right after the stop bit is caught.
        if (at_decide) begin
          ctr_d = '0;
          if (maj) begin
            state_d = IDLE;
            if (!valid_q || rx.RX_ACK) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        ctr_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ctr_d   = '0;
      end
    endcase
  end

  assign rx.RX_DATA  = data_q;
  assign rx.RX_VALID = valid_q;
  assign FRAME_ERR   = ferr_q;
  assign OVERRUN     = ovr_q;
  assign BUSY        = (state_q != IDLE);

endmodule

// File: tb/tb_fast_8n1_uart_rx.sv
// Self-checking bench for fast_8n1_uart_rx: serial frames driven bit by bit,
// results compared with a byte-level holding-register model.
module tb_fast_8n1_uart_rx;

  localparam int SYSCLK_F = 24000000;
  localparam int BAUDRATE = 500000;
  localparam int BYTE_W   = 8;
  localparam int CPB      = SYSCLK_F / BAUDRATE;
  localparam int MID      = CPB / 2;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic en      = 1'b1;
  logic rx_line = 1'b1;
  logic frame_err, overrun, busy;

  fast_8n1_uart_rx_if #(.BYTE_W(BYTE_W)) rx_bus ();

  fast_8n1_uart_rx #(
    .SYSCLK_F (SYSCLK_F),
    .BYTE_W   (BYTE_W),
    .BAUDRATE (BAUDRATE)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .en        (en),
    .RX_LINE   (rx_line),
    .rx        (rx_bus.master),
    .FRAME_ERR (frame_err),
    .OVERRUN   (overrun),
    .BUSY      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  bit         auto_ack  = 1'b0;
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  int         exp_loads = 0;
  int         exp_ferr  = 0;
  int         exp_ovr   = 0;

  int   valid_rises = 0;
  int   ferr_pulses = 0;
  int   ovr_pulses  = 0;
  int   both_high   = 0;
  logic valid_prev  = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte-level model of the holding register: good frames load or overrun, bad stops count errors.
  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good)          exp_ferr++;
    else if (exp_valid) exp_ovr++;
    else begin
      exp_valid = 1'b1;
      exp_data  = b;
      exp_loads++;
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_valid"}, rx_bus.RX_VALID, exp_valid);
    checkOutput({tag, "_data"},  rx_bus.RX_DATA,  exp_data);
    checkOutput({tag, "_loads"}, valid_rises,     exp_loads);
    checkOutput({tag, "_ferr"},  ferr_pulses,     exp_ferr);
    checkOutput({tag, "_ovr"},   ovr_pulses,      exp_ovr);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input int stop_bits,
                               input bit counted, input int glitch_bit);
    rx_line = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      if (i == glitch_bit) begin
        repeat (MID) @(negedge sys_clk);
        rx_line = 1'b0;
        @(negedge sys_clk);
        rx_line = b[i];
        repeat (CPB - MID - 1) @(negedge sys_clk);
      end else begin
        repeat (CPB) @(negedge sys_clk);
      end
    end
    rx_line = stop_ok;
    repeat (MID) @(negedge sys_clk);
    if (counted) model_frame(b, stop_ok);
    repeat (CPB * stop_bits - MID) @(negedge sys_clk);
    rx_line = 1'b1;
  endtask

  task automatic ackByte();
    rx_bus.RX_ACK = 1'b1;
    exp_valid     = 1'b0;
    @(negedge sys_clk);
    rx_bus.RX_ACK = 1'b0;
    checkOutput("ack_clear", rx_bus.RX_VALID, exp_valid);
  endtask

  always @(negedge sys_clk) begin
    if (rx_bus.RX_VALID && !valid_prev) valid_rises <= valid_rises + 1;
    if (frame_err)                      ferr_pulses <= ferr_pulses + 1;
    if (overrun)                        ovr_pulses  <= ovr_pulses + 1;
    if (frame_err && overrun)           both_high   <= both_high + 1;
    valid_prev <= rx_bus.RX_VALID;
  end

  // Auto-consumer: checks each presented byte against the model, then acks it.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (auto_ack && rx_bus.RX_VALID) begin
        checkOutput("auto_data", rx_bus.RX_DATA, exp_data);
        rx_bus.RX_ACK = 1'b1;
        exp_valid     = 1'b0;
        @(negedge sys_clk);
        rx_bus.RX_ACK = 1'b0;
        checkOutput("auto_clear", rx_bus.RX_VALID, exp_valid);
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         lat;
    int         busy_cnt;
    int         gap;

    rx_bus.RX_ACK = 1'b0;
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_valid", rx_bus.RX_VALID, 1'b0);
    checkOutput("rst_data",  rx_bus.RX_DATA,  8'h00);
    checkOutput("rst_ferr",  frame_err,       1'b0);
    checkOutput("rst_ovr",   overrun,         1'b0);
    checkOutput("rst_busy",  busy,            1'b0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge sys_clk);

    $display("[TB] single frame 0xA5 with latency");
    fork
      applyStimulus(8'hA5, 1'b1, 1, 1'b1, -1);
      begin
        lat = 0;
        while (!rx_bus.RX_VALID && lat < 20 * CPB) begin
          @(negedge sys_clk);
          lat++;
        end
      end
    join
    checkOutput("a5_latency_ok", (lat >= 9 * CPB + MID) && (lat <= 9 * CPB + MID + 8), 1'b1);
    checkModel("a5");
    ackByte();
    repeat (CPB) @(negedge sys_clk);

    $display("[TB] 10-cycle glitch on idle line");
    busy_cnt = 0;
    rx_line  = 1'b0;
    for (int i = 0; i < 3 * CPB; i++) begin
      if (i == 10) rx_line = 1'b1;
      @(negedge sys_clk);
      if (busy) busy_cnt++;
    end
    checkOutput("glitch_busy_ok", (busy_cnt >= MID) && (busy_cnt <= MID + 4), 1'b1);
    checkOutput("glitch_idle", busy, 1'b0);
    checkModel("glitch");

    $display("[TB] 0xFF with 1-cycle glitch in bit 3");
    applyStimulus(8'hFF, 1'b1, 1, 1'b1, 3);
    checkModel("ff_glitch");
    ackByte();
    repeat (CPB) @(negedge sys_clk);

    $display("[TB] framing error then recovery");
    applyStimulus(8'h3C, 1'b0, 2, 1'b1, -1);
    repeat (CPB) @(negedge sys_clk);
    checkModel("ferr");
    applyStimulus(8'h81, 1'b1, 1, 1'b1, -1);
    checkModel("after_ferr");
    ackByte();
    repeat (CPB) @(negedge sys_clk);

    $display("[TB] back-to-back with ack");
    auto_ack = 1'b1;
    applyStimulus(8'h00, 1'b1, 1, 1'b1, -1);
    applyStimulus(8'hFF, 1'b1, 1, 1'b1, -1);
    repeat (CPB) @(negedge sys_clk);
    auto_ack = 1'b0;
    checkModel("b2b_ack");

    $display("[TB] back-to-back without ack");
    applyStimulus(8'h00, 1'b1, 1, 1'b1, -1);
    applyStimulus(8'hFF, 1'b1, 1, 1'b1, -1);
    repeat (CPB) @(negedge sys_clk);
    checkModel("b2b_ovr");
    ackByte();
    repeat (CPB) @(negedge sys_clk);

    $display("[TB] reset during data bit 4");
    b = 8'($urandom);
    applyStimulus(b, 1'b1, 1, 1'b1, -1);
    repeat (CPB) @(negedge sys_clk);
    checkModel("pre_rst");
    b = 8'($urandom);
    rx_line = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      rx_line = b[i];
      repeat (CPB) @(negedge sys_clk);
    end
    rx_line = b[4];
    repeat (MID) @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    checkOutput("midrst_valid", rx_bus.RX_VALID, exp_valid);
    checkOutput("midrst_data",  rx_bus.RX_DATA,  exp_data);
    checkOutput("midrst_busy",  busy,            1'b0);
    checkOutput("midrst_ferr",  frame_err,       1'b0);
    checkOutput("midrst_ovr",   overrun,         1'b0);
    rx_line = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge sys_clk);
    applyStimulus(8'h5A, 1'b1, 1, 1'b1, -1);
    checkModel("post_rst");
    ackByte();
    repeat (CPB) @(negedge sys_clk);

    $display("[TB] enable behaviour");
    en = 1'b0;
    applyStimulus(8'h11, 1'b1, 1, 1'b0, -1);
    repeat (CPB) @(negedge sys_clk);
    checkModel("en_off");
    fork
      applyStimulus(8'hF1, 1'b1, 1, 1'b0, -1);
      begin
        repeat (3 * CPB) @(negedge sys_clk);
        en = 1'b1;
      end
    join
    repeat (CPB) @(negedge sys_clk);
    checkModel("en_late");
    applyStimulus(8'h11, 1'b1, 1, 1'b1, -1);
    checkModel("en_on");
    ackByte();
    repeat (CPB) @(negedge sys_clk);
    b = 8'($urandom);
    fork
      applyStimulus(b, 1'b1, 1, 1'b1, -1);
      begin
        repeat (2 * CPB) @(negedge sys_clk);
        en = 1'b0;
      end
    join
    checkModel("en_drop");
    ackByte();
    en = 1'b1;
    repeat (CPB) @(negedge sys_clk);

    $display("[TB] random traffic");
    auto_ack = 1'b1;
    for (int k = 0; k < 12; k++) begin
      b   = 8'($urandom);
      gap = int'($urandom_range(0, 2));
      applyStimulus(b, 1'b1, 1, 1'b1, -1);
      repeat (gap * CPB) @(negedge sys_clk);
    end
    repeat (2 * CPB) @(negedge sys_clk);
    auto_ack = 1'b0;
    checkModel("random");
    checkOutput("never_both", both_high, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
